// File: rtl/traffic_pkg.sv
// Shared light encodings and controller state codes for the traffic light controller.
package traffic_pkg;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;

  typedef enum logic [2:0] {
    ST_STARTUP = 3'd0,
    ST_GREEN   = 3'd1,
    ST_YELLOW  = 3'd2,
    ST_ALLRED  = 3'd3,
    ST_FLASH   = 3'd4
  } state_e;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks, on the last count.
module tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(TICK_DIV - 1));

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/traffic_ctrl.sv
// Multi-direction traffic light controller: round-robin or demand-driven green,
// yellow/all-red clearance, and a tick-synchronous flash override.
module traffic_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_DIR  = 4,
  parameter int TICK_DIV = 50000000,
  parameter int GREEN_T  = 5,
  parameter int YELLOW_T = 1,
  parameter int ALLRED_T = 1,
  parameter int SKIP_EN  = 0,
  localparam int PW = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_DIR-1:0]   dir_req,
  input  logic                 flash_req,
  output logic [2*NUM_DIR-1:0] lights,
  output logic [PW-1:0]        phase,
  output logic [2:0]           state_o,
  output logic                 tick_o
);

  localparam int MAX_GY = (GREEN_T > YELLOW_T) ? GREEN_T : YELLOW_T;
  localparam int MAX_T  = (MAX_GY > ALLRED_T) ? MAX_GY : ALLRED_T;
  localparam int DW     = $clog2(MAX_T + 1);

  localparam logic [DW-1:0] D_GREEN  = DW'(GREEN_T - 1);
  localparam logic [DW-1:0] D_YELLOW = DW'(YELLOW_T - 1);
  localparam logic [DW-1:0] D_ALLRED = DW'((ALLRED_T > 0) ? ALLRED_T - 1 : 0);

  logic                 tick;
  state_e               state_q, state_d;
  logic [PW-1:0]        phase_q, phase_d;
  logic [PW-1:0]        nxt_q, nxt_d;
  logic [DW-1:0]        dwell_q, dwell_d;
  logic                 flash_q, flash_d;
  logic [2*NUM_DIR-1:0] lights_q, lights_d;
  logic [PW-1:0]        cand;
  logic [PW-1:0]        idx;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Descending scan so the last hit is the nearest requester after phase; phase itself comes last.
  always_comb begin
    cand = PW'((int'(phase_q) + 1) % NUM_DIR);
    idx  = '0;
    if ((SKIP_EN != 0) && (|dir_req)) begin
      for (int k = NUM_DIR; k >= 1; k--) begin
        idx = PW'((int'(phase_q) + k) % NUM_DIR);
        if (dir_req[idx]) cand = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    nxt_d   = nxt_q;
    dwell_d = dwell_q;
    flash_d = flash_q;
    if (tick) begin
      if (flash_req) begin
        state_d = ST_FLASH;
        flash_d = (state_q == ST_FLASH) ? ~flash_q : 1'b1;
      end else if (state_q == ST_FLASH) begin
        state_d = ST_STARTUP;
        phase_d = '0;
        nxt_d   = '0;
        dwell_d = D_YELLOW;
        flash_d = 1'b0;
      end else if (dwell_q != '0) begin
        dwell_d = dwell_q - DW'(1);
      end else begin
        case (state_q)
          ST_STARTUP: begin
            state_d = ST_GREEN;
            phase_d = '0;
            dwell_d = D_GREEN;
          end
          ST_GREEN: begin
            nxt_d   = cand;
            dwell_d = D_GREEN;
            if (cand != phase_q) begin
              state_d = ST_YELLOW;
              dwell_d = D_YELLOW;
            end
          end
          ST_YELLOW: begin
            if (ALLRED_T == 0) begin
              state_d = ST_GREEN;
              phase_d = nxt_q;
              dwell_d = D_GREEN;
            end else begin
              state_d = ST_ALLRED;
              dwell_d = D_ALLRED;
            end
          end
          ST_ALLRED: begin
            state_d = ST_GREEN;
            phase_d = nxt_q;
            dwell_d = D_GREEN;
          end
          default: begin
            state_d = ST_STARTUP;
            phase_d = '0;
            nxt_d   = '0;
            dwell_d = D_YELLOW;
          end
        endcase
      end
    end
  end

  // Lamps are decoded from next-state so the registered outputs track the state register.
  for (genvar gi = 0; gi < NUM_DIR; gi++) begin : g_lamp
    localparam logic [PW-1:0] DIR = PW'(gi);
    logic [1:0] lamp;
    always_comb begin
      lamp = RED;
      case (state_d)
        ST_STARTUP: lamp = YELLOW;
        ST_GREEN:   lamp = (phase_d == DIR) ? GREEN : RED;
        ST_YELLOW:  lamp = ((phase_d == DIR) || (nxt_d == DIR)) ? YELLOW : RED;
        ST_FLASH:   lamp = flash_d ? YELLOW : RED;
        default:    lamp = RED;
      endcase
    end
    assign lights_d[2*gi +: 2] = lamp;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_STARTUP;
      phase_q  <= '0;
      nxt_q    <= '0;
      dwell_q  <= D_YELLOW;
      flash_q  <= 1'b0;
      lights_q <= {NUM_DIR{YELLOW}};
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      nxt_q    <= nxt_d;
      dwell_q  <= dwell_d;
      flash_q  <= flash_d;
      lights_q <= lights_d;
    end
  end

  assign lights  = lights_q;
  assign phase   = phase_q;
  assign state_o = state_q;
  assign tick_o  = tick;

endmodule

// File: doc/traffic_ctrl.md
TRAFFIC_CTRL -- requirements
Module: traffic_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIR, 4, number of approach directions (legal 2..8).
REQ-002 SHALL have parameter TICK_DIV, 50000000, clock cycles per timing tick (>=2).
REQ-003 SHALL have parameter GREEN_T, 5, green dwell in ticks (>=1).
REQ-004 SHALL have parameter YELLOW_T, 1, yellow and startup dwell in ticks (>=1).
REQ-005 SHALL have parameter ALLRED_T, 1, all-red clearance in ticks (0 = state skipped).
REQ-006 SHALL have parameter SKIP_EN, 0, 1 = demand-driven direction selection.
REQ-007 SHALL have port clk, input, 1, single clock. One clock; reset is synchronous and active-low.
REQ-008 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-009 SHALL have port dir_req, input, NUM_DIR, per-direction vehicle demand, level-sampled.
REQ-010 SHALL have port flash_req, input, 1, night/fault flash mode request.
REQ-011 SHALL have port lights, output, 2*NUM_DIR, registered; direction i occupies bits [2i+1:2i]; red=00, yellow=01, green=10; 11 never driven.
REQ-012 SHALL have port phase, output, max(1,$clog2(NUM_DIR)), index of the active direction.
REQ-013 SHALL have port state_o, output, 3, current FSM state code.
REQ-014 SHALL have port tick_o, output, 1, one-cycle pulse per tick.

Function
REQ-015 Prescaler SHALL count 0..TICK_DIV-1, wrap, and assert tick_o only in the cycle the count equals TICK_DIV-1.
REQ-016 FSM states SHALL be STARTUP, GREEN, YELLOW, ALLRED, FLASH; all transitions occur only on tick cycles.
REQ-017 Each state SHALL load dwell counter with its duration minus 1 on entry, decrement on each tick, and exit on the tick where dwell is 0, giving exactly duration*TICK_DIV cycles.
REQ-018 STARTUP: all directions yellow, YELLOW_T ticks, then GREEN with phase=0.
REQ-019 GREEN: direction phase green, others red; at expiry next direction nxt is computed and registered.
REQ-020 With SKIP_EN=0 or dir_req all zero, nxt SHALL be (phase+1) mod NUM_DIR.
REQ-021 With SKIP_EN=1 and dir_req nonzero, nxt SHALL be the first set bit searching phase+1, phase+2, ... wrapping, phase itself last.
REQ-022 If nxt equals phase, GREEN SHALL restart for another GREEN_T ticks with no yellow.
REQ-023 YELLOW: directions phase and nxt yellow, others red, YELLOW_T ticks, then ALLRED (or GREEN if ALLRED_T=0).
REQ-024 ALLRED: all red for ALLRED_T ticks; at exit phase<=nxt, enter GREEN.
REQ-025 flash_req SHALL be sampled on tick cycles only and SHALL preempt any state, entering FLASH on that tick.
REQ-026 FLASH: all lights yellow on the entry tick, alternating all-red/all-yellow every tick thereafter.
REQ-027 Exit from FLASH SHALL occur on the first tick with flash_req low, going to STARTUP with phase=0.
REQ-028 dir_req changes between ticks SHALL have no effect except at GREEN expiry.

Reset
REQ-029 When rst_n is low at a clk edge: state=STARTUP, phase=0, nxt=0, prescaler=0, dwell=YELLOW_T-1, flash toggle=0, tick_o=0.
REQ-030 lights SHALL equal all-yellow the cycle after reset is sampled, including reset mid-operation.

Structure
REQ-031 Package traffic_pkg SHALL hold light encodings (RED, YELLOW, GREEN) and the state enum/codes.
REQ-032 Prescaler SHALL be sub-module tick_gen (params TICK_DIV; ports clk, rst_n, tick).

Verification (NUM_DIR=4, TICK_DIV=4, GREEN_T=3, YELLOW_T=1, ALLRED_T=1)
REQ-033 Release reset -> lights=0x55 for 4 cycles, 0x02 for 12, 0x05 for 4, 0x00 for 4, then 0x08 with phase=1.
REQ-034 SKIP_EN=1, dir_req=4'b1000 during dir0 green -> yellow 0x41, all-red 0x00, green 0x80, phase=3.
REQ-035 SKIP_EN=1, dir_req=4'b0001 held -> dir0 green 0x02 continuous for 24+ cycles, no yellow.
REQ-036 flash_req high mid-GREEN -> next tick 0x55, then 0x00/0x55 per tick; drop -> 0x55 for 4 cycles, then 0x02.
REQ-037 rst_n low one cycle during ALLRED -> next cycle lights=0x55, phase=0, state_o=STARTUP.
REQ-038 NUM_DIR=3, run full cycle -> phase sequence 0,1,2,0; YELLOW at phase 2 gives lights=0x11.
